pipelined_ripple_adder: RTL and testbench



---
 rtl/pipelined_ripple_adder.sv | 86 ++++++++
 tb/tb_pipelined_ripple_adder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, global-stall valid/ready handshake on both sides.
module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int STAGES     = WIDTH / CHUNK_SAFE;

  if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
    $error("pipelined_ripple_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Level 0 captures the operands; level k+1 holds the result of stage k. acc starts as A and
  // rotates right one slice per stage, with each finished sum slice entering at the top, so the
  // live slice is always at the bottom and the full sum is aligned after the last stage.
  logic [STAGES:0]  v_q, v_d;
  logic [STAGES:0]  c_q, c_d;
  logic [WIDTH-1:0] acc_q [STAGES+1];
  logic [WIDTH-1:0] acc_d [STAGES+1];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [CHUNK:0]   slice [STAGES];
  logic             cmsb_q, cmsb_d;
  logic             advance;

  assign advance   = !v_q[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = v_q[STAGES];
  assign sum       = acc_q[STAGES];
  assign cout      = c_q[STAGES];
  assign ovf       = cmsb_q ^ c_q[STAGES];

  // NOTE: every combinational output is assigned on every path, so no latch is inferred.
  always_comb begin
    v_d[0]   = in_valid;
    c_d[0]   = sub | cin;
    acc_d[0] = a;
    opb_d[0] = sub ? ~b : b;
    for (int k = 0; k < STAGES; k++) begin
      slice[k]   = {1'b0, acc_q[k][CHUNK-1:0]} + {1'b0, opb_q[k][CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_q[k]};
      v_d[k+1]   = v_q[k];
      c_d[k+1]   = slice[k][CHUNK];
      acc_d[k+1] = (acc_q[k] >> CHUNK) | (WIDTH'(slice[k][CHUNK-1:0]) << (WIDTH - CHUNK));
    end
    for (int k = 1; k < STAGES; k++) begin
      opb_d[k] = (opb_q[k-1] >> CHUNK) | (opb_q[k-1] << (WIDTH - CHUNK));
    end
    // Carry into the MSB recovered from the MSB's own operand and sum bits.
    cmsb_d = acc_q[STAGES-1][CHUNK-1] ^ opb_q[STAGES-1][CHUNK-1]
           ^ slice[STAGES-1][CHUNK-1];
  end

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the per-stage arrays are plain flops rather than a RAM, so they take the reset.
      v_q    <= '0;
      c_q    <= '0;
      cmsb_q <= 1'b0;
      acc_q  <= '{default: '0};
      opb_q  <= '{default: '0};
    end else if (advance) begin
      v_q    <= v_d;
      c_q    <= c_d;
      cmsb_q <= cmsb_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
    end
  end
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench: default 16/4 instance for directed, backpressure and reset scenarios,
// plus 16/16 and 32/8 instances under long random add/sub streams.
module tb_pipelined_ripple_adder;
  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic clk = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic ci, input logic sub_v);
    exp_t   e;
    longint lim, ua, ub, sa, sbv, r, sr;
    lim = longint'(1) << w;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = av[w-1] ? ua - lim : ua;
    sbv = bv[w-1] ? ub - lim : ub;
    if (sub_v) begin
      r      = ua - ub;
      sr     = sa - sbv;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub + longint'(ci);
      sr     = sa + sbv + longint'(ci);
      e.cout = (r >= lim);
    end
    e.ovf     = (sr >= lim / 2) || (sr < -(lim / 2));
    e.sum     = 32'(r & (lim - 1));
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  // ---------------- default-parameter instance ----------------
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  exp_t        q_main[$];

  pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial begin : main_monitor
    bit          prev_stall = 1'b0;
    logic [15:0] prev_sum   = '0;
    logic        prev_cout  = 1'b0, prev_ovf = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (prev_stall) begin
          check("hold_sum", sum, prev_sum);
          check("hold_cout", cout, prev_cout);
          check("hold_ovf", ovf, prev_ovf);
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
        prev_cout  = cout;
        prev_ovf   = ovf;
        if (out_valid && out_ready) begin
          if (q_main.size() == 0) begin
            fail("unexpected_out", $sformatf("sum=%0h with no beat outstanding", sum));
          end else begin
            e = q_main.pop_front();
            check("sum", sum, e.sum[15:0]);
            check("cout", cout, e.cout);
            check("ovf", ovf, e.ovf);
            if (e.chk_lat) check("latency", cyc - e.acc_cyc, 4);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_main(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                           input logic s, input bit lat);
    exp_t e;
    a = av; b = bv; cin = ci; sub = s; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(16, 32'(av), 32'(bv), ci, s);
        e.acc_cyc = cyc + 1;
        e.chk_lat = lat;
        q_main.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    fail("send_timeout", "in_ready never seen within 200 cycles, required 1");
  endtask

  task automatic drain_main();
    for (int t = 0; t < 200 && q_main.size() != 0; t++) @(negedge clk);
    check("drain", q_main.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] d_a [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [15:0] d_b [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001};
  bit          d_c [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  bit          d_s [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  bit          rnd_done = 1'b0;

  initial begin : main_stim
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      send_main(d_a[i], d_b[i], d_c[i], d_s[i], 1'b1);
      drain_main();
    end

    // Eight back-to-back beats; out_ready low for 3 cycles while results are presented.
    fork
      for (int i = 0; i < 8; i++)
        send_main(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain_main();

    // Three beats in flight, then an asynchronous reset pulse between edges.
    for (int i = 0; i < 3; i++)
      send_main(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_inflight", q_main.size(), 3);
    q_main.delete();
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;

    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_main(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain_main();

    for (int t = 0; t < 60000 && !(g_sweep[0].done && g_sweep[1].done); t++) @(posedge clk);
    check("sweep_done", {g_sweep[0].done, g_sweep[1].done}, 2'b11);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int W   = (g == 0) ? 16 : 32;
    localparam int C   = (g == 0) ? 16 : 8;
    localparam int LAT = W / C;

    logic         s_rst, iv, ir, ci, sb, ov, orr, co, of;
    logic [W-1:0] av, bv, sm;
    exp_t         q[$];
    bit           stim_done = 1'b0;
    bit           done      = 1'b0;

    pipelined_ripple_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk(clk), .rst(s_rst), .in_valid(iv), .in_ready(ir),
      .a(av), .b(bv), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(orr),
      .sum(sm), .cout(co), .ovf(of)
    );

    initial begin : drive
      exp_t e;
      bit   acc;
      s_rst = 1'b1; iv = 1'b0; av = '0; bv = '0; ci = 1'b0; sb = 1'b0;
      repeat (2) @(posedge clk);
      #1 s_rst = 1'b0;
      for (int n = 0; n < 10000; n++) begin
        if ($urandom_range(0, 4) == 0) begin
          iv = 1'b0;
          @(posedge clk);
          #1;
        end
        av = W'($urandom); bv = W'($urandom); ci = 1'($urandom); sb = 1'($urandom);
        iv = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
          @(negedge clk);
          if (ir) begin
            e = model(W, 32'(av), 32'(bv), ci, sb);
            e.acc_cyc = cyc + 1;
            q.push_back(e);
            acc = 1'b1;
          end
          @(posedge clk);
          #1;
        end
        if (!acc) fail("sweep_send_timeout", "in_ready never seen within 100 cycles");
      end
      iv = 1'b0;
      stim_done = 1'b1;
      for (int t = 0; t < 200 && q.size() != 0; t++) @(negedge clk);
      check("sweep_drain", q.size(), 0);
      done = 1'b1;
    end

    initial begin : ready_gen
      orr = 1'b0;
      while (!stim_done) begin
        @(posedge clk);
        #1 orr = ($urandom_range(0, 3) != 0);
      end
      orr = 1'b1;
    end

    initial begin : monitor
      exp_t e;
      forever begin
        @(negedge clk);
        if (!s_rst) begin
          check("sweep_in_ready", ir, !(ov && !orr));
          if (ov && orr) begin
            if (q.size() == 0) begin
              fail("sweep_unexpected_out", $sformatf("W=%0d sum=%0h with none outstanding", W, sm));
            end else begin
              e = q.pop_front();
              check("sweep_sum", sm, e.sum[W-1:0]);
              check("sweep_cout", co, e.cout);
              check("sweep_ovf", of, e.ovf);
              check("sweep_min_latency", (cyc - e.acc_cyc) >= LAT, 1);
            end
          end
        end
      end
    end
  end
endmodule
